sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one single-port 1024x32 SRAM macro between NUM_REQ requesters (e.g. DMA, core load/store, debug).
- Round-robin arbitration with per-requester valid/ready request channels and one-cycle-latency read responses.
- Drives the SRAM wrapper pins directly: CEB, WEB, A, D, Q.
- Sits between the requesters and the SRAM wrapper; owns chip-enable gating during scan.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
NUM_WORD, 1024, SRAM depth in words
NUM_BIT, 32, SRAM word width
ADDR_W, $clog2(NUM_WORD), address width
ID_W, $clog2(NUM_REQ), grant index width

Ports:
CLK  in  1  clock, rising edge
RSTB  in  1  synchronous reset, active-low
scan_en_in  in  1  scan mode; blocks all grants
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*NUM_BIT  packed write data
rsp_valid  out  NUM_REQ  one-cycle read-data strobe to the owning requester
rsp_rdata  out  NUM_BIT  read data, shared bus, qualified by rsp_valid
sram_ceb  out  1  to SRAM CEB, active-low
sram_web  out  1  to SRAM WEB, 0 = write
sram_a  out  ADDR_W  to SRAM A
sram_d  out  NUM_BIT  to SRAM D
sram_q  in  NUM_BIT  from SRAM Q

Behaviour:
- Reset (RSTB=0 at CLK edge):
  - rr_ptr=0.
  - rsp_valid=0 and rsp_id=0.
  - Lock state (if compiled in) = IDLE.
  - Combinational outputs are inactive while RSTB=0: req_ready=0, sram_ceb=1.
- Arbitration (combinational, same cycle):
  - Candidates are requesters with req_valid=1.
  - Grant goes to the first candidate at or after rr_ptr, in ascending index order with wrap-around.
  - req_ready[g]=1 only for the granted index g; at most one bit is high.
  - Handshake completes when req_valid[g] & req_ready[g].
- SRAM drive:
  - On a handshake: sram_ceb=0, sram_web=~req_we[g], sram_a=req_addr[g], sram_d=req_wdata[g].
  - With no handshake: sram_ceb=1, and sram_a/sram_d hold the value of the last grant (no toggling).
- Pointer update: after each handshake, rr_ptr <= g+1, wrapping at NUM_REQ to 0. No handshake leaves rr_ptr unchanged.
- Read response:
  - A read handshake in cycle N sets rsp_valid[g]=1 in cycle N+1 only, with rsp_rdata=sram_q.
  - rsp_id is a registered ID_W copy of g.
  - rsp_rdata is a pass-through of sram_q; it is valid only while rsp_valid is high.
  - A write produces no response.
  - Back-to-back reads from any mix of requesters sustain one per cycle.
- Scan: scan_en_in=1 forces req_ready=0 and sram_ceb=1 in the same cycle. A response already in flight still completes.
- Reset mid-operation: an in-flight response is dropped (rsp_valid=0 next cycle). No SRAM access occurs while RSTB=0.
- Requesters must hold valid, we, addr and wdata stable until ready. The arbiter does not check this.
- Simultaneous events:
  - A requester may issue a new request in the same cycle it receives rsp_valid.
  - A requester whose valid is low is skipped with no penalty cycle.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- With the macro: adds input req_lock [NUM_REQ].
  - A handshake with req_lock[g]=1 moves the lock FSM IDLE->LOCKED(owner=g).
  - In LOCKED, only the owner may be granted; other requesters see ready=0 even while the owner is idle.
  - An owner handshake with req_lock=0 returns the FSM to IDLE and advances rr_ptr past the owner.
  - Watchdog: a 4-bit counter of consecutive LOCKED cycles without an owner handshake. On reaching 15 it forces IDLE.
  - scan_en_in does not change the lock state.
- Without the macro: no req_lock port, no FSM, pure round-robin.

Decomposition:
- Package sram_arb_pkg:
  - localparams NUM_WORD=1024, NUM_BIT=32, ADDR_W.
  - Lock FSM enum lock_state_e {LK_IDLE, LK_LOCKED}.
  - Watchdog limit LOCK_WD_MAX=15.
- Sub-module rr_arbiter: combinational round-robin, inputs req vector and rr_ptr, outputs one-hot grant and grant index.
- The top keeps all registers.

Test Plan:
- Reset check: after RSTB low for 2 cycles, expect rsp_valid=0, sram_ceb=1, req_ready=0. After release, requesters 0,1,2 all valid -> grants in order 0,1,2,0.
- Write/read: req1 writes 0xDEADBEEF to addr 0x155, then req2 reads 0x155 -> rsp_valid[2]=1 exactly one cycle after the read handshake, rsp_rdata=0xDEADBEEF, rsp_valid[0..1]=0.
- Fairness with a gap: only req0 and req2 valid continuously for 6 cycles -> grants 0,2,0,2,0,2; req1 is never granted and no idle cycles occur.
- Scan blocking: assert scan_en_in during continuous requests -> sram_ceb=1 and req_ready=0 that same cycle. A read issued the previous cycle still returns rsp_valid.
- Reset mid-read: read handshake at cycle N, RSTB=0 at cycle N+1 -> rsp_valid=0 at N+1 and rr_ptr=0 afterwards.
- Lock (SRAM_ARB_LOCK_EN):
  - req0 locks while req1 is valid -> req1 is denied until req0 unlocks, then granted next.
  - Owner goes idle for 15 cycles -> the lock is released and req1 is granted.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for sram_port_arbiter (SRAM macro geometry, lock FSM).
// The lock types are only used when SRAM_ARB_LOCK_EN is defined.
package sram_arb_pkg;
  localparam int NUM_WORD    = 1024;
  localparam int NUM_BIT     = 32;
  localparam int ADDR_W      = $clog2(NUM_WORD);
  localparam int LOCK_WD_MAX = 15;

  typedef enum logic [0:0] {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester channels, SRAM macro pins and debug taps of sram_port_arbiter.
// SRAM_ARB_LOCK_EN adds req_lock and the lock-state debug tap.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int NUM_BIT = sram_arb_pkg::NUM_BIT,
  parameter int ADDR_W  = sram_arb_pkg::ADDR_W,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import sram_arb_pkg::*;

  // Request i transfers on a cycle with req_valid[i] & req_ready[i]; the requester
  // holds valid/we/addr/wdata stable until then. rsp_valid[i] is a one-cycle strobe.
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_we;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*NUM_BIT-1:0] req_wdata;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_BIT-1:0]         rsp_rdata;
  logic                       sram_ceb;
  logic                       sram_web;
  logic [ADDR_W-1:0]          sram_a;
  logic [NUM_BIT-1:0]         sram_d;
  logic [NUM_BIT-1:0]         sram_q;
  logic [ID_W-1:0]            dbg_rr_ptr;
  logic [ID_W-1:0]            dbg_rsp_id;

`ifdef SRAM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]         req_lock;
  lock_state_e                dbg_lock_state;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lock, sram_q,
    input  req_ready, rsp_valid, rsp_rdata, sram_ceb, sram_web, sram_a, sram_d,
           dbg_rr_ptr, dbg_rsp_id, dbg_lock_state
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lock, sram_q,
    output req_ready, rsp_valid, rsp_rdata, sram_ceb, sram_web, sram_a, sram_d,
           dbg_rr_ptr, dbg_rsp_id, dbg_lock_state
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_q,
    input  req_ready, rsp_valid, rsp_rdata, sram_ceb, sram_web, sram_a, sram_d,
           dbg_rr_ptr, dbg_rsp_id
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_q,
    output req_ready, rsp_valid, rsp_rdata, sram_ceb, sram_web, sram_a, sram_d,
           dbg_rr_ptr, dbg_rsp_id
  );
`endif
endinterface

// File: rtl/sram_port_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, ascending with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);
  int              pos;
  logic [ID_W-1:0] pos_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = ID_W'(pos);
      if (!gnt_any && req[pos_idx]) begin
        gnt[pos_idx] = 1'b1;
        gnt_idx      = pos_idx;
        gnt_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM macro between NUM_REQ requesters.
// Define SRAM_ARB_LOCK_EN to add req_lock and the lock FSM with its watchdog.
module sram_port_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_WORD = sram_arb_pkg::NUM_WORD,
  parameter int NUM_BIT  = sram_arb_pkg::NUM_BIT,
  parameter int ADDR_W   = $clog2(NUM_WORD),
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic               scan_en_in,
  sram_port_arbiter_if.slave bus
);
  import sram_arb_pkg::*;

  logic [NUM_REQ-1:0] cand, gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any, allow, hs;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [NUM_BIT-1:0] sel_wdata;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]  a_q, a_d;
  logic [NUM_BIT-1:0] d_q, d_d;
  logic               web_q, web_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req     (cand),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

`ifdef SRAM_ARB_LOCK_EN
  lock_state_e     lock_state_q, lock_state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [3:0]      wd_q, wd_d;
  logic            sel_lock;

  // While locked only the owner is a candidate, even when it is idle.
  always_comb begin
    cand = bus.req_valid;
    if (lock_state_q == LK_LOCKED) cand = bus.req_valid & (NUM_REQ'(1) << owner_q);
  end

  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
    wd_d         = wd_q;
    case (lock_state_q)
      LK_IDLE: begin
        if (hs && sel_lock) begin
          lock_state_d = LK_LOCKED;
          owner_d      = gnt_idx;
          wd_d         = '0;
        end
      end
      LK_LOCKED: begin
        if (hs) begin
          wd_d = '0;
          if (!sel_lock) lock_state_d = LK_IDLE;
        end else if (!scan_en_in) begin
          if (wd_q == 4'(LOCK_WD_MAX - 1)) begin
            lock_state_d = LK_IDLE;
            wd_d         = '0;
          end else begin
            wd_d = wd_q + 4'd1;
          end
        end
      end
      default: lock_state_d = LK_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      lock_state_q <= LK_IDLE;
      owner_q      <= '0;
      wd_q         <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
      wd_q         <= wd_d;
    end
  end

  assign bus.dbg_lock_state = lock_state_q;
`else
  always_comb cand = bus.req_valid;
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
`ifdef SRAM_ARB_LOCK_EN
    sel_lock  = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*NUM_BIT +: NUM_BIT];
`ifdef SRAM_ARB_LOCK_EN
        sel_lock  = bus.req_lock[i];
`endif
      end
    end
  end

  // Address/data/WEB hold their last granted values so the macro pins stay quiet when idle.
  always_comb begin
    allow       = RSTB & ~scan_en_in;
    hs          = allow & gnt_any;
    a_d         = hs ? sel_addr : a_q;
    d_d         = hs ? sel_wdata : d_q;
    web_d       = hs ? ~sel_we : web_q;
    rr_ptr_d    = rr_ptr_q;
    if (hs) rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    rsp_valid_d = (hs && !sel_we) ? gnt_oh : '0;
    rsp_id_d    = hs ? gnt_idx : rsp_id_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      rr_ptr_q    <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= '0;
      a_q         <= '0;
      d_q         <= '0;
      web_q       <= 1'b1;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      a_q         <= a_d;
      d_q         <= d_d;
      web_q       <= web_d;
    end
  end

  assign bus.req_ready  = hs ? gnt_oh : '0;
  assign bus.sram_ceb   = ~hs;
  assign bus.sram_web   = web_d;
  assign bus.sram_a     = a_d;
  assign bus.sram_d     = d_d;
  // Masked by RSTB so a read in flight when reset arrives is never presented.
  assign bus.rsp_valid  = RSTB ? rsp_valid_q : '0;
  assign bus.rsp_rdata  = bus.sram_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;
  assign bus.dbg_rsp_id = rsp_id_q;
endmodule
